// File: rtl/mult_div_ctrl.sv
// Multicycle signed MULT/DIV sequencer: shift-add multiply, restoring divide, HI/LO write pulses.
// Optional abort input is enabled by defining MULT_DIV_CTRL_ABORT_EN.
module mult_div_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             hi_write,
   output logic             lo_write,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             div_zero
`ifdef MULT_DIV_CTRL_ABORT_EN
   ,
   input  logic             abort
`endif
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {IDLE, RUN, FIX, DONE, DZERO} state_t;
   state_t state, state_nx;

   logic [CW-1:0]      count;
   logic               op_r, neg_hi, neg_lo;
   logic [WIDTH-1:0]   opd, acc_hi, acc_lo;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     add_sum, shifted, diff;
   logic [2*WIDTH-1:0] prod_neg;
   logic               b_zero, abort_w;

`ifdef MULT_DIV_CTRL_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   assign b_zero = (b_in == '0);
   assign mag_a  = a_in[WIDTH-1] ? -a_in : a_in;
   assign mag_b  = b_in[WIDTH-1] ? -b_in : b_in;

   // Multiply: acc_hi accumulates, acc_lo holds the multiplier and shifts out LSB-first.
   // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
   assign add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
   assign shifted  = {acc_hi, acc_lo[WIDTH-1]};
   assign diff     = shifted - {1'b0, opd};
   assign prod_neg = -{acc_hi, acc_lo};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b1;
      done     = 1'b0;
      hi_write = 1'b0;
      lo_write = 1'b0;
      div_zero = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = (op && b_zero) ? DZERO : RUN;
         end
         RUN: begin
            if (abort_w)             state_nx = IDLE;
            else if (count == LAST)  state_nx = FIX;
         end
         FIX:  state_nx = abort_w ? IDLE : DONE;
         DONE: begin
            done     = 1'b1;
            hi_write = 1'b1;
            lo_write = 1'b1;
            state_nx = IDLE;
         end
         DZERO: begin
            div_zero = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count  <= '0;
         op_r   <= 1'b0;
         neg_hi <= 1'b0;
         neg_lo <= 1'b0;
         opd    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         hi_out <= '0;
         lo_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !(op && b_zero)) begin
                  count  <= '0;
                  op_r   <= op;
                  neg_lo <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                  neg_hi <= op ? a_in[WIDTH-1] : (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                  acc_hi <= '0;
                  if (op) begin
                     opd    <= mag_b;
                     acc_lo <= mag_a;
                  end else begin
                     opd    <= mag_a;
                     acc_lo <= mag_b;
                  end
               end
            end
            RUN: begin
               count <= count + CW'(1);
               if (!op_r) begin
                  {acc_hi, acc_lo} <= {add_sum, acc_lo[WIDTH-1:1]};
               end else if (!diff[WIDTH]) begin
                  acc_hi <= diff[WIDTH-1:0];
                  acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
               end else begin
                  acc_hi <= shifted[WIDTH-1:0];
                  acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
               end
            end
            FIX: begin
               if (!abort_w) begin
                  if (!op_r) begin
                     {hi_out, lo_out} <= neg_lo ? prod_neg : {acc_hi, acc_lo};
                  end else begin
                     hi_out <= neg_hi ? -acc_hi : acc_hi;
                     lo_out <= neg_lo ? -acc_lo : acc_lo;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed corner cases plus random ops against a longint model.
module tb_mult_div_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        op    = 1'b0;
   logic [31:0] a_in  = '0;
   logic [31:0] b_in  = '0;
   logic        busy, done, hi_write, lo_write, div_zero;
   logic [31:0] hi_out, lo_out;
`ifdef MULT_DIV_CTRL_ABORT_EN
   logic        abort = 1'b0;
`endif

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [31:0] ehi = '0;
   logic [31:0] elo = '0;

   always #5 clock = ~clock;

   mult_div_ctrl #(.WIDTH(32)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a_in     (a_in),
      .b_in     (b_in),
      .busy     (busy),
      .done     (done),
      .hi_write (hi_write),
      .lo_write (lo_write),
      .hi_out   (hi_out),
      .lo_out   (lo_out),
      .div_zero (div_zero)
`ifdef MULT_DIV_CTRL_ABORT_EN
      ,
      .abort    (abort)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain signed 64-bit arithmetic; SV '/' truncates toward zero, '%' follows dividend.
   function automatic void model(input logic o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      longint sa, sb, p, q, r;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      if (!o) begin
         p  = sa * sb;
         hi = p[63:32];
         lo = p[31:0];
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         hi = r[31:0];
         lo = q[31:0];
      end
   endfunction

   // Observation index k = value present at edge k, where edge 0 samples start.
   task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [31:0] nhi, nlo, got_hi, got_lo;
      logic        dz;
      int unsigned done_at, n_done, n_dz, dz_at, n_busy, n_wr_bad;
      dz = o && (b == 32'd0);
      if (dz) begin
         nhi = ehi;
         nlo = elo;
      end else begin
         model(o, a, b, nhi, nlo);
      end
      done_at = 0; n_done = 0; n_dz = 0; dz_at = 0; n_busy = 0; n_wr_bad = 0;
      got_hi = '0; got_lo = '0;
      @(negedge clock);
      start = 1'b1; op = o; a_in = a; b_in = b;
      @(posedge clock);
      #1;
      start = 1'b0; a_in = $urandom; b_in = $urandom;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (busy) n_busy++;
         if (done) begin
            n_done++;
            done_at = k;
            got_hi  = hi_out;
            got_lo  = lo_out;
         end
         if (hi_write !== done || lo_write !== done) n_wr_bad++;
         if (div_zero) begin
            n_dz++;
            dz_at = k;
         end
         if (!dz && k == 10) begin
            start = 1'b1;
            a_in  = 32'd9;
         end
         if (k == 11) start = 1'b0;
      end
      if (!dz) begin
         chk({tag, " done_at"}, 64'(done_at), 64'd34);
         chk({tag, " n_done"},  64'(n_done),  64'd1);
         chk({tag, " hi@done"}, 64'(got_hi),  64'(nhi));
         chk({tag, " lo@done"}, 64'(got_lo),  64'(nlo));
         chk({tag, " n_dz"},    64'(n_dz),    64'd0);
         chk({tag, " n_busy"},  64'(n_busy),  64'd34);
      end else begin
         chk({tag, " n_done"},  64'(n_done),  64'd0);
         chk({tag, " dz_at"},   64'(dz_at),   64'd1);
         chk({tag, " n_dz"},    64'(n_dz),    64'd1);
         chk({tag, " n_busy"},  64'(n_busy),  64'd1);
      end
      chk({tag, " wr_vs_done"}, 64'(n_wr_bad), 64'd0);
      chk({tag, " hi_hold"},    64'(hi_out),   64'(nhi));
      chk({tag, " lo_hold"},    64'(lo_out),   64'(nlo));
      ehi = nhi;
      elo = nlo;
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        ro;
      int unsigned n_pulse;

      // Reset state
      @(negedge clock);
      chk("rst busy",     64'(busy),     64'd0);
      chk("rst done",     64'(done),     64'd0);
      chk("rst hi_write", 64'(hi_write), 64'd0);
      chk("rst lo_write", 64'(lo_write), 64'd0);
      chk("rst div_zero", 64'(div_zero), 64'd0);
      chk("rst hi_out",   64'(hi_out),   64'd0);
      chk("rst lo_out",   64'(lo_out),   64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Directed cases
      do_op(1'b0, 32'd7,         32'hFFFF_FFFD, "mul 7*-3");
      do_op(1'b1, 32'hFFFF_FFF9, 32'd2,         "div -7/2");
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
      do_op(1'b1, 32'd5,         32'd0,         "div 5/0");
      do_op(1'b0, 32'd3,         32'd4,         "mul 3*4");
      do_op(1'b0, 32'h8000_0000, 32'h8000_0000, "mul min*min");
      do_op(1'b1, 32'd7,         32'hFFFF_FFFE, "div 7/-2");

      // Reset in the middle of an operation
      @(negedge clock);
      start = 1'b1; op = 1'b0; a_in = 32'd1234; b_in = 32'd5678;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (19) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("midrst busy",   64'(busy),   64'd0);
      chk("midrst hi_out", 64'(hi_out), 64'd0);
      chk("midrst lo_out", 64'(lo_out), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      n_pulse = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (done || hi_write || lo_write) n_pulse++;
      end
      chk("midrst no_pulse", 64'(n_pulse), 64'd0);
      chk("midrst lo_hold",  64'(lo_out),  64'd0);
      ehi = '0;
      elo = '0;

`ifdef MULT_DIV_CTRL_ABORT_EN
      // Abort during RUN: no completion, outputs kept
      @(negedge clock);
      start = 1'b1; op = 1'b1; a_in = 32'd100; b_in = 32'd7;
      @(posedge clock);
      #1 start = 1'b0;
      n_pulse = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (done || hi_write || lo_write) n_pulse++;
         if (k == 16) chk("abort busy@16", 64'(busy), 64'd0);
         abort = (k == 15);
      end
      abort = 1'b0;
      chk("abort no_pulse", 64'(n_pulse), 64'(0));
      chk("abort hi_hold",  64'(hi_out),  64'(ehi));
      chk("abort lo_hold",  64'(lo_out),  64'(elo));
      do_op(1'b1, 32'd100, 32'd7, "div 100/7 after abort");
`endif

      // Randomized operations
      for (int i = 0; i < 16; i++) begin
         ro = 1'($urandom);
         case ($urandom_range(0, 4))
            0:       ra = 32'h8000_0000;
            1:       ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = $urandom_range(1, 9);
            default: rb = $urandom;
         endcase
         do_op(ro, ra, rb, ro ? "rand div" : "rand mul");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
